interface_tx: RTL and testbench
===============================

Name: interface_tx

Overview:
- Transmit-side counterpart of interface_rx: accepts result words from the ALU (`wr` strobe plus data) and buffers them in a small FIFO.
- Sequences each word into tx_module one at a time: pulses `tx_start`, then waits for `tx_done_tick` before sending the next.
- Sits between ALU and tx_module in Main, so back-to-back results are not lost while the serializer is busy.

Parameters:
- DBIT, 8, data word width; must match tx_module DBIT.
- FIFO_W, 2, FIFO address width; depth = 2^FIFO_W entries.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- wr  input  1  one-cycle write strobe from ALU
- din  input  DBIT  result word, sampled when wr=1
- tx_done_tick  input  1  one-cycle pulse from tx_module when its stop bit ends
- tx_start  output  1  one-cycle start pulse to tx_module
- tx_din  output  DBIT  byte presented to tx_module, held stable from tx_start until tx_done_tick
- tx_empty  output  1  FIFO empty
- tx_full  output  1  FIFO full
- overflow  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, async):
  - FIFO pointers cleared; FSM returns to IDLE.
  - tx_start=0, tx_din=0, tx_empty=1, tx_full=0, overflow=0.
  - A frame in progress is abandoned; any in-flight tx_module byte is ignored.
- FIFO write:
  - On a clk edge with wr=1 and tx_full=0, din is stored at the write pointer and the pointer increments, wrapping at 2^FIFO_W.
  - wr=1 with tx_full=1: word dropped, overflow set to 1; it stays 1 until reset.
  - Full and empty are judged on the registered state before the edge. A write and a pop on the same edge are both performed; the count is unchanged.
  - A write on a full FIFO is dropped even if a pop occurs on the same edge.
- FIFO count (0..2^FIFO_W):
  - tx_empty = (count==0); tx_full = (count==2^FIFO_W).
- FSM states: IDLE, SEND, WAIT.
  - IDLE: if tx_empty=0, pop head into the word register and go to SEND; else stay.
  - SEND: drive tx_din = current byte, assert tx_start=1 for exactly this one cycle, go to WAIT.
  - WAIT: tx_start=0 and tx_din held. On tx_done_tick=1, go to the next byte of the frame (SEND) or, if the frame is complete, to IDLE.
  - tx_done_tick while in IDLE or SEND is ignored.
- Latency: with the FSM idle and the FIFO empty, wr on edge n gives:
  - pop on edge n+1;
  - tx_start high in the cycle after edge n+2.
- Back-to-back: after tx_done_tick in WAIT with the FIFO non-empty, the next tx_start follows exactly 2 cycles after the tick (IDLE then SEND).
- Ordering: strict FIFO; no reordering, no duplication.

Optional Feature:
- Macro: TX_FRAME_EN.
- Defined: each FIFO word is sent as a 3-byte frame, each byte its own SEND/WAIT pair:
  - header 8'hA5;
  - data word;
  - checksum = 8'hA5 XOR data.
  - Requires DBIT=8.
  - Return to IDLE only after the third tx_done_tick.
- Undefined: one byte (the data word) per FIFO entry; no header or checksum logic is synthesized.

Test Plan:
- Reset then idle → tx_start=0, tx_din=0, tx_empty=1, tx_full=0, overflow=0.
- Single wr with din=8'h3C; model tx_done_tick 20 cycles after tx_start:
  - no TX_FRAME_EN → one tx_start 2 edges after wr, tx_din=8'h3C held until the tick, then tx_empty=1 and IDLE;
  - TX_FRAME_EN → bytes A5, 3C, 99 in order.
- Four consecutive wr (8'h01..8'h04, FIFO_W=2) while the first is sending → all four transmitted in order, tx_full=1 reached, overflow=0.
- Five wr in five cycles with no tx_done_tick → tx_full=1, fifth word dropped, overflow=1 and still 1 after all entries drain.
- Spurious tx_done_tick while in IDLE and in SEND → no state change, no extra tx_start.
- reset=0 asserted in WAIT mid-frame with 2 words queued → outputs return to reset values immediately (async); after release no tx_start until a new wr.

Source files
------------

// File: rtl/interface_tx.sv
// interface_tx: FIFO-buffers ALU result words and feeds them to tx_module one byte per start/done handshake.
// Build macro TX_FRAME_EN: each word goes out as a 3-byte frame (8'hA5, data, 8'hA5 ^ data); requires DBIT=8.
module interface_tx #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] din,
    input  logic            tx_done_tick,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_din,
    output logic            tx_empty,
    output logic            tx_full,
    output logic            overflow
);
    localparam int DEPTH = 1 << FIFO_W;
    localparam logic [FIFO_W:0] FULL_CNT = (FIFO_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [FIFO_W-1:0] wptr_q;
    logic [FIFO_W-1:0] rptr_q;
    logic [FIFO_W:0]   count_q;
    logic              overflow_q;
    state_t            state_q, state_d;
    logic [DBIT-1:0]   word_q, word_d;
    logic              tx_start_q, tx_start_d;
    logic [DBIT-1:0]   tx_din_q, tx_din_d;
    logic              push;
    logic              pop;

    assign tx_empty = (count_q == '0);
    assign tx_full  = (count_q == FULL_CNT);
    assign push     = wr && !tx_full;
    assign tx_start = tx_start_q;
    assign tx_din   = tx_din_q;
    assign overflow = overflow_q;

`ifdef TX_FRAME_EN
    localparam logic [DBIT-1:0] HDR = DBIT'(8'hA5);

    logic [1:0] idx_q, idx_d;

    function automatic logic [DBIT-1:0] frame_byte(input logic [1:0] idx, input logic [DBIT-1:0] w);
        case (idx)
            2'd0:    frame_byte = HDR;
            2'd1:    frame_byte = w;
            default: frame_byte = HDR ^ w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idx_q <= 2'd0;
        else        idx_q <= idx_d;
    end
`endif

    // FIFO storage holds only data, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // a full FIFO drops the write even when a pop happens on the same edge
            if (wr && tx_full) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        tx_start_d = 1'b0;
        tx_din_d   = tx_din_q;
        pop        = 1'b0;
`ifdef TX_FRAME_EN
        idx_d      = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (!tx_empty) begin
                    pop     = 1'b1;
                    word_d  = mem_q[rptr_q];
                    state_d = SEND;
`ifdef TX_FRAME_EN
                    idx_d   = 2'd0;
`endif
                end
            end
            SEND: begin
                // start and byte are registered, so they appear together in the first WAIT cycle
                tx_start_d = 1'b1;
`ifdef TX_FRAME_EN
                tx_din_d   = frame_byte(idx_q, word_q);
`else
                tx_din_d   = word_q;
`endif
                state_d    = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
`ifdef TX_FRAME_EN
                    if (idx_q != 2'd2) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_din_q   <= tx_din_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule

// File: tb/tb_interface_tx.sv
// Directed bench for interface_tx with a behavioural tx_module responder (done tick DELAY cycles after start).
`timescale 1ns/1ps
module tb_interface_tx;
    localparam int DELAY = 20;
`ifdef TX_FRAME_EN
    localparam int BPW = 3;
`else
    localparam int BPW = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       tx_empty;
    logic       tx_full;
    logic       overflow;

    interface_tx #(.DBIT(8), .FIFO_W(2)) dut (
        .clk(clk), .reset(reset), .wr(wr), .din(din), .tx_done_tick(tx_done_tick),
        .tx_start(tx_start), .tx_din(tx_din), .tx_empty(tx_empty), .tx_full(tx_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int tick_edge = 0;
    int n_start = 0;
    int wr_edge = 0;
    bit busy = 1'b0;
    bit resp_en = 1'b1;
    bit hold_bad = 1'b0;
    logic [7:0] hold_val = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int start_q[$];
    int gap_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: sample after the edge, record starts, and model the tx_module done tick.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tx_done_tick = 1'b0;
        if (busy && tx_din !== hold_val) hold_bad = 1'b1;
        if (tx_start === 1'b1) begin
            n_start++;
            got_q.push_back(tx_din);
            start_q.push_back(cyc);
            gap_q.push_back(cyc - tick_edge);
            hold_val = tx_din;
            if (resp_en) begin
                busy = 1'b1;
                tick_cnt = DELAY;
            end
        end else if (busy) begin
            tick_cnt--;
            if (tick_cnt == 0) begin
                tx_done_tick = 1'b1;
                busy = 1'b0;
                tick_edge = cyc + 1;
            end
        end
    endtask

    task automatic write(input logic [7:0] d);
        wr = 1'b1;
        din = d;
        step();
        wr = 1'b0;
    endtask

    function automatic void push_exp(input logic [7:0] w);
`ifdef TX_FRAME_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(w);
        exp_q.push_back(8'hA5 ^ w);
`else
        exp_q.push_back(w);
`endif
    endfunction

    task automatic clear_model();
        got_q.delete();
        exp_q.delete();
        start_q.delete();
        gap_q.delete();
        hold_bad = 1'b0;
    endtask

    task automatic wait_start(input int n0, input int maxc, input string tag);
        for (int k = 0; k < maxc && n_start == n0; k++) step();
        check(tag, 32'(n_start > n0), 32'd1);
    endtask

    task automatic drain(input int maxc, input string tag);
        int k;
        for (k = 0; k < maxc && (got_q.size() < exp_q.size() || busy); k++) step();
        check({"drain_", tag}, 32'(k < maxc), 32'd1);
        repeat (5) step();
    endtask

    task automatic compare_bytes(input string tag);
        logic [7:0] g;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), g, exp_q[i]);
        end
        check({tag, "_hold"}, hold_bad, 1'b0);
    endtask

    initial begin
        int n0;

        // reset state
        #12;
        check("rst_start", tx_start, 1'b0);
        check("rst_din", tx_din, 8'h00);
        check("rst_empty", tx_empty, 1'b1);
        check("rst_full", tx_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        step();
        reset = 1'b1;
        repeat (5) step();
        check("idle_no_start", n_start, 0);

        // single word: latency 2 edges after the write edge
        clear_model();
        push_exp(8'h3C);
        write(8'h3C);
        wr_edge = cyc;
        drain(300, "single");
        check("single_latency", (start_q.size() > 0) ? start_q[0] - wr_edge : -1, 2);
        compare_bytes("single");
        check("single_empty", tx_empty, 1'b1);

        // four writes while the first word is on the wire fill the FIFO
        clear_model();
        push_exp(8'hF0);
        n0 = n_start;
        write(8'hF0);
        wait_start(n0, 10, "burst_first_start");
        for (int i = 1; i <= 4; i++) begin
            write(8'(i));
            push_exp(8'(i));
        end
        check("burst_full", tx_full, 1'b1);
        check("burst_not_empty", tx_empty, 1'b0);
        check("burst_ovf", overflow, 1'b0);
        drain(1500, "burst");
        compare_bytes("burst");
        check("burst_b2b_gap", (gap_q.size() > BPW) ? gap_q[BPW] : -1, 2);
        check("burst_ovf_end", overflow, 1'b0);
        check("burst_empty_end", tx_empty, 1'b1);

        // overflow with the serializer stalled
        clear_model();
        resp_en = 1'b0;
        push_exp(8'h11);
        n0 = n_start;
        write(8'h11);
        wait_start(n0, 10, "ovf_first_start");
        for (int i = 1; i <= 4; i++) begin
            write(8'h20 + 8'(i));
            push_exp(8'h20 + 8'(i));
        end
        check("ovf_full", tx_full, 1'b1);
        check("ovf_before", overflow, 1'b0);
        write(8'h25);
        check("ovf_set", overflow, 1'b1);
        check("ovf_still_full", tx_full, 1'b1);
        resp_en = 1'b1;
        tx_done_tick = 1'b1;
        tick_edge = cyc + 1;
        step();
        drain(1500, "ovf");
        compare_bytes("ovf");
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_empty_end", tx_empty, 1'b1);

        // spurious ticks in IDLE and SEND
        clear_model();
        n0 = n_start;
        tx_done_tick = 1'b1;
        step();
        repeat (3) step();
        check("spur_idle_nostart", n_start - n0, 0);
        check("spur_idle_empty", tx_empty, 1'b1);
        push_exp(8'h5A);
        write(8'h5A);
        wr_edge = cyc;
        step();
        tx_done_tick = 1'b1;
        step();
        drain(300, "spur");
        compare_bytes("spur");
        check("spur_starts", n_start - n0, BPW);
        check("spur_latency", (start_q.size() > 0) ? start_q[0] - wr_edge : -1, 2);

        // asynchronous reset in WAIT with two words still queued
        clear_model();
        resp_en = 1'b0;
        n0 = n_start;
        write(8'hA1);
        write(8'hA2);
        write(8'hA3);
        check("midrst_started", n_start - n0, 1);
        check("midrst_queued", tx_empty, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_start", tx_start, 1'b0);
        check("midrst_din", tx_din, 8'h00);
        check("midrst_empty", tx_empty, 1'b1);
        check("midrst_full", tx_full, 1'b0);
        check("midrst_ovf", overflow, 1'b0);
        busy = 1'b0;
        step();
        step();
        reset = 1'b1;
        resp_en = 1'b1;
        n0 = n_start;
        repeat (30) step();
        check("postrst_nostart", n_start - n0, 0);
        check("postrst_empty", tx_empty, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
